// File: rtl/led_page_select_pkg.sv
// led_page_select_pkg: LED number field positions and page stepping helper
package led_page_select_pkg;

    localparam int LED_DP_PAGE_HI = 19;
    localparam int LED_DP_PAGE_LO = 18;
    localparam int LED_DP_FROZEN  = 17;
    localparam int LED_DP_ACT     = 16;
    localparam int LED_NUM_W      = 20;
    localparam int PAGE_W         = 16;

    typedef logic [1:0] page_t;

    // Advance to the next page, wrapping after the last populated one.
    function automatic page_t page_step(input page_t p, input int num_pages);
        return (int'(p) >= num_pages - 1) ? page_t'(0) : page_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronizes a raw pushbutton, filters bounces, emits a press pulse
module button_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic mclk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    logic                     sync1_q, sync2_q;
    logic                     level_q, level_d;
    logic                     press_q, press_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

    // Count consecutive cycles where the synced input disagrees with the accepted level.
    always_comb begin
        cnt_d   = (sync2_q == level_q || &cnt_q) ? '0 : cnt_q + 1'b1;
        level_d = (sync2_q != level_q && &cnt_q) ? sync2_q : level_q;
        press_d = level_d & ~level_q;
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_page_select.sv
// led_page_select: picks a debug word page for the hex LED driver with freeze and activity dots
module led_page_select
    import led_page_select_pkg::*;
#(
    parameter int NUM_PAGES     = 4,
    parameter int DEBOUNCE_BITS = 16,
    parameter int ACT_BITS      = 22
) (
    input  logic                    mclk,
    input  logic                    reset,
    input  logic                    btn_next,
    input  logic                    btn_hold,
    input  logic                    activity,
    input  logic [16*NUM_PAGES-1:0] page_data,
    output logic [LED_NUM_W-1:0]    number,
    output logic [1:0]              page
);

    logic                 next_press, hold_press;
    logic [1:0]           levels_unused;
    page_t                page_q, page_d;
    logic                 frozen_q, frozen_d;
    logic [ACT_BITS-1:0]  act_q, act_d;
    logic [LED_NUM_W-1:0] num_q, num_d;
    logic [PAGE_W-1:0]    word;

    button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_next (
        .mclk  (mclk),
        .reset (reset),
        .raw   (btn_next),
        .level (levels_unused[0]),
        .press (next_press)
    );

    button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_hold (
        .mclk  (mclk),
        .reset (reset),
        .raw   (btn_hold),
        .level (levels_unused[1]),
        .press (hold_press)
    );

    // Page step, freeze toggle, activity stretch and the word shown on the digits.
    always_comb begin
        page_d   = next_press ? page_step(page_q, NUM_PAGES) : page_q;
        frozen_d = frozen_q ^ hold_press;
        act_d    = activity ? '1 : ((act_q != '0) ? act_q - 1'b1 : act_q);
        word     = page_data[{page_d, 4'b0000} +: PAGE_W];
        num_d    = num_q;
        num_d[LED_DP_PAGE_HI:LED_DP_PAGE_LO] = page_d;
        num_d[LED_DP_FROZEN] = frozen_d;
        num_d[LED_DP_ACT]    = act_q != '0;
        num_d[PAGE_W-1:0]    = (!frozen_q || next_press) ? word : num_q[PAGE_W-1:0];
    end

    // Display state registers.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            page_q   <= '0;
            frozen_q <= 1'b0;
            act_q    <= '0;
            num_q    <= '0;
        end else begin
            page_q   <= page_d;
            frozen_q <= frozen_d;
            act_q    <= act_d;
            num_q    <= num_d;
        end
    end

    assign number = num_q;
    assign page   = page_q;

endmodule

// File: tb/tb_led_page_select.sv
// tb_led_page_select: randomized and directed checks of led_page_select against a behavioural model
module tb_led_page_select;

    localparam int NP  = 4;
    localparam int DB  = 2;
    localparam int ACT = 3;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_hold = 1'b0;
    logic        activity = 1'b0;
    logic [15:0] pd [NP];
    logic [63:0] page_data;
    logic [19:0] number;
    logic [1:0]  page;

    int total = 0;
    int bad = 0;

    assign page_data = {pd[3], pd[2], pd[1], pd[0]};

    led_page_select #(.NUM_PAGES(NP), .DEBOUNCE_BITS(DB), .ACT_BITS(ACT)) dut (
        .mclk      (mclk),
        .reset     (reset),
        .btn_next  (btn_next),
        .btn_hold  (btn_hold),
        .activity  (activity),
        .page_data (page_data),
        .number    (number),
        .page      (page)
    );

    always #5 mclk = ~mclk;

    // Behavioural model: raw -> 2-cycle delay -> accept after 2^DB disagreeing cycles.
    logic       s1 [2];
    logic       s2 [2];
    logic       lvl [2];
    logic       prs [2];
    int         run [2];
    logic [1:0] m_page = 0;
    logic       m_frozen = 0;
    logic       m_act = 0;
    logic [15:0] m_data = 0;
    int         since = -1;
    logic       pn, ph, wf;
    logic       r [2];

    always @(posedge mclk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                s1[b] = 0; s2[b] = 0; lvl[b] = 0; prs[b] = 0; run[b] = 0;
            end
            m_page = 0; m_frozen = 0; m_act = 0; m_data = 0; since = -1;
        end else begin
            pn = prs[0];
            ph = prs[1];
            wf = m_frozen;
            if (pn) m_page = 2'((int'(m_page) + 1) % NP);
            if (ph) m_frozen = ~m_frozen;
            if (!wf || pn) m_data = pd[m_page];
            m_act = (since != -1) && (since + 1 <= (1 << ACT) - 1);
            if (activity) since = 0;
            else if (since != -1 && since < 1000) since++;
            r[0] = btn_next;
            r[1] = btn_hold;
            for (int b = 0; b < 2; b++) begin
                prs[b] = 0;
                if (s2[b] != lvl[b]) begin
                    run[b]++;
                    if (run[b] == (1 << DB)) begin
                        lvl[b] = s2[b];
                        run[b] = 0;
                        prs[b] = lvl[b];
                    end
                end else run[b] = 0;
                s2[b] = s1[b];
                s1[b] = r[b];
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge mclk) begin
        total++;
        if (number !== {m_page, m_frozen, m_act, m_data} || page !== m_page) begin
            bad++;
            $display("FAIL model t=%0t number=%h page=%0d want number=%h page=%0d",
                     $time, number, page, {m_page, m_frozen, m_act, m_data}, m_page);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic press(input int b, input int n);
        if (b != 1) btn_next = 1'b1;
        if (b != 0) btn_hold = 1'b1;
        tick(n);
        btn_next = 1'b0;
        btn_hold = 1'b0;
        tick(8);
    endtask

    int lat;
    logic [1:0] pg0;
    logic [1:0] exp_pages [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        pd[0] = 16'hAAAA; pd[1] = 16'hBBBB; pd[2] = 16'hCCCC; pd[3] = 16'hDDDD;
        tick(2);
        check("reset number", 32'(number), 32'h0);
        check("reset page", 32'(page), 32'h0);
        reset = 1'b0;
        tick(2);
        check("tracking page0", 32'(number), 32'h0AAAA);
        for (int i = 0; i < 5; i++) begin
            press(0, 10);
            check("next step page", 32'(page), 32'(exp_pages[i]));
        end
        check("after five presses", 32'(number), 32'h4BBBB);
        btn_next = 1'b1;
        tick(2);
        btn_next = 1'b0;
        tick(10);
        check("glitch rejected", 32'(page), 32'h1);
        lat = 0;
        pg0 = page;
        btn_next = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (lat == 0 && page != pg0) lat = k;
        end
        btn_next = 1'b0;
        tick(8);
        check("next latency", 32'(lat), 32'd7);
        check("single press", 32'(page), 32'h2);
        press(1, 10);
        pd[2] = 16'h1234;
        tick(3);
        check("frozen hold", 32'(number), 32'hACCCC);
        press(0, 10);
        check("frozen capture", 32'(number), 32'hEDDDD);
        pd[3] = 16'h5555;
        tick(3);
        check("capture once", 32'(number), 32'hEDDDD);
        pd[2] = 16'hCCCC; pd[3] = 16'hDDDD;
        press(1, 10);
        check("unfrozen", 32'(number), 32'hCDDDD);
        press(0, 10);
        check("wrap page0", 32'(number), 32'h0AAAA);
        press(2, 10);
        check("next+hold", 32'(number), 32'h6BBBB);
        press(1, 10);
        check("unfreeze page1", 32'(number), 32'h4BBBB);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        check("act strobe cycle", 32'(number[16]), 32'h0);
        for (int c = 1; c <= 9; c++) begin
            tick(1);
            check("act single", 32'(number[16]), 32'(c <= 7));
        end
        activity = 1'b1;
        tick(1);
        for (int c = 1; c <= 13; c++) begin
            activity = (c == 4);
            tick(1);
            check("act retrigger", 32'(number[16]), 32'(c <= 11));
        end
        activity = 1'b0;
        btn_next = 1'b1;
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("async reset number", 32'(number), 32'h0);
        check("async reset page", 32'(page), 32'h0);
        @(negedge mclk);
        reset = 1'b0;
        tick(12);
        btn_next = 1'b0;
        tick(8);
        check("held through reset", 32'(page), 32'h1);
        repeat (4000) begin
            @(negedge mclk);
            if ($urandom_range(0, 7) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 9) == 0) btn_hold = ~btn_hold;
            activity = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) pd[$urandom_range(0, 3)] = 16'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset = 1'b1;
                @(negedge mclk);
                reset = 1'b0;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
